// File: rtl/rv_mem_loader_resp_pkg.sv
// Shared types and constants for the polirv memory responder and its boot loader.
package rv_mem_loader_resp_pkg;

    localparam int IMEM_WIDTH = 32;
    localparam int DMEM_WIDTH = 64;
    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } loader_state_t;

endpackage

// File: rtl/rv_mem_array.sv
// Word-addressed storage with synchronous write and asynchronous (combinational) read.
module rv_mem_array #(
    parameter int width     = 32,
    parameter int addr_bits = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [width-1:0]     wdata,
    input  logic [addr_bits-1:0] raddr,
    output logic [width-1:0]     rdata
);

    logic [width-1:0] mem [2**addr_bits];

    // Contents are deliberately not reset so an image survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rv_mem_loader_resp.sv
// Instruction/data memory responder with boot loader for the polirv core.
// Optional LOAD_CHECKSUM_EN: accumulate a 32-bit wraparound sum of loaded words on load_sum.
module rv_mem_loader_resp
    import rv_mem_loader_resp_pkg::*;
#(
    parameter int i_addr_bits = 6,
    parameter int d_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [IMEM_WIDTH-1:0]  i_mem_data,
    input  logic                   d_mem_we,
    input  logic [d_addr_bits-1:0] d_mem_addr,
    inout  wire  [DMEM_WIDTH-1:0]  d_mem_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [IMEM_WIDTH-1:0]  load_data,
    input  logic                   load_last,
    output logic                   cpu_rst_n,
    output logic                   load_done,
    output logic [31:0]            load_sum
);

    loader_state_t          state;
    logic [i_addr_bits-1:0] wr_ptr;
    logic                   transfer;
    logic                   at_end;
    logic                   running;
    logic                   dmem_we;
    logic [DMEM_WIDTH-1:0]  dmem_rdata;

    assign load_ready = (state == ST_LOAD);
    assign transfer   = load_valid && load_ready;
    assign at_end     = (wr_ptr == {i_addr_bits{1'b1}});
    assign running    = (state == ST_RUN);
    assign dmem_we    = running && d_mem_we;

    // Loader FSM: the core is held in reset until the cycle after RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (transfer) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (load_last || at_end) begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    state     <= ST_RUN;
                    cpu_rst_n <= 1'b1;
                    load_done <= 1'b1;
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_sum <= '0;
        end else if (transfer) begin
            load_sum <= load_sum + load_data;
        end
    end
`else
    assign load_sum = '0;
`endif

    rv_mem_array #(
        .width     (IMEM_WIDTH),
        .addr_bits (i_addr_bits)
    ) imem (
        .clk   (clk),
        .we    (transfer),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (i_mem_addr),
        .rdata (i_mem_data)
    );

    rv_mem_array #(
        .width     (DMEM_WIDTH),
        .addr_bits (d_addr_bits)
    ) dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (d_mem_addr),
        .wdata (d_mem_data),
        .raddr (d_mem_addr),
        .rdata (dmem_rdata)
    );

    // Bus is driven only for RUN-state reads; ownership flips combinationally with d_mem_we.
    assign d_mem_data = (running && !d_mem_we) ? dmem_rdata : {DMEM_WIDTH{1'bz}};

endmodule
